// File: rtl/spi_frame_master.sv
// rtl/spi_frame_master.sv - serial memory-access frame initiator (optional txn counter: SPI_FRAME_MASTER_TXN_CNT_EN)
module spi_frame_master #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 16,
    parameter int TA_CYCLES = 2,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              sdo,
    input  logic              sdi,
    output logic              cs_n,
    output logic              busy,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata
`ifdef SPI_FRAME_MASTER_TXN_CNT_EN
    ,
    output logic [15:0]       txn_cnt
`endif
);

    localparam int AC_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
    localparam int TC_W = (TA_CYCLES > 1) ? $clog2(TA_CYCLES) : 1;
    localparam int DC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RW,
        TA,
        DATA,
        GAP
    } state_t;

    state_t            state;
    logic [AC_W-1:0]   addr_cnt;
    logic [TC_W-1:0]   ta_cnt;
    logic [DC_W-1:0]   data_cnt;
    logic [ADDR_W-1:0] addr_sr;
    logic [DATA_W-1:0] wdata_sr;
    logic [DATA_W-1:0] rd_sr;
    logic              we_q;
    logic              data_d;
    logic              cap_en;
    logic [DATA_W-1:0] rd_final;

    // sdi for a data slot is sampled in that slot (RD_LAT=0) or one cycle later (RD_LAT=1)
    assign cap_en   = (RD_LAT == 0) ? (state == DATA) : data_d;
    // with a one-cycle read latency the last bit is still on sdi during GAP
    assign rd_final = (RD_LAT == 0) ? rd_sr : {rd_sr[DATA_W-2:0], sdi};

    // frame sequencer with registered serial outputs and read-data capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            ta_cnt    <= '0;
            data_cnt  <= '0;
            addr_sr   <= '0;
            wdata_sr  <= '0;
            rd_sr     <= '0;
            we_q      <= 1'b0;
            data_d    <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            cs_n      <= 1'b1;
            sdo       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef SPI_FRAME_MASTER_TXN_CNT_EN
            txn_cnt   <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            data_d    <= (state == DATA);
            if (cap_en) begin
                rd_sr <= {rd_sr[DATA_W-2:0], sdi};
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= ADDR;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        cs_n      <= 1'b0;
                        sdo       <= req_addr[ADDR_W-1];
                        addr_sr   <= req_addr << 1;
                        addr_cnt  <= '0;
                        we_q      <= req_we;
                        wdata_sr  <= req_wdata;
                    end
                end
                ADDR: begin
                    if (addr_cnt == AC_W'(ADDR_W - 1)) begin
                        state <= RW;
                        sdo   <= we_q;
                    end else begin
                        addr_cnt <= addr_cnt + 1'b1;
                        sdo      <= addr_sr[ADDR_W-1];
                        addr_sr  <= addr_sr << 1;
                    end
                end
                RW: begin
                    state  <= TA;
                    ta_cnt <= '0;
                    sdo    <= 1'b0;
                end
                TA: begin
                    if (ta_cnt == TC_W'(TA_CYCLES - 1)) begin
                        state    <= DATA;
                        data_cnt <= '0;
                        sdo      <= we_q & wdata_sr[DATA_W-1];
                        wdata_sr <= wdata_sr << 1;
                    end else begin
                        ta_cnt <= ta_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (data_cnt == DC_W'(DATA_W - 1)) begin
                        state <= GAP;
                        cs_n  <= 1'b1;
                        sdo   <= 1'b0;
                    end else begin
                        data_cnt <= data_cnt + 1'b1;
                        sdo      <= we_q & wdata_sr[DATA_W-1];
                        wdata_sr <= wdata_sr << 1;
                    end
                end
                GAP: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b1;
                    if (!we_q) begin
                        rsp_rdata <= rd_final;
                    end
`ifdef SPI_FRAME_MASTER_TXN_CNT_EN
                    txn_cnt   <= txn_cnt + 16'd1;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
